pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-003 The block SHALL have parameter FETCH_WIDTH, default 1 (legal 1, 2, 4), meaning instructions per fetch; STEP = 4*FETCH_WIDTH bytes.
REQ-004 The block SHALL have parameter ALIGN_CHECK, default 1, meaning 1 = flag misaligned targets, 0 = force target[1:0] to 0.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port stall, input, 1 bit: freeze PC advance.
REQ-008 The block SHALL have port pc_read_ready, input, 1 bit: fetch accepted the presented pc this cycle.
REQ-009 The block SHALL have ports branch_flag_i (input, 1) and branch_target_address_i (input, ADDR_W): redirect request and target.
REQ-010 The block SHALL have ports flush (input, 1) and new_pc (input, ADDR_W): exception redirect and handler entry.
REQ-011 The block SHALL have port pc, output, ADDR_W: registered fetch address.
REQ-012 The block SHALL have port ce, output, 1 bit: fetch enable.
REQ-013 The block SHALL have port redirect_pending_o, output, 1 bit: a captured redirect awaits acceptance.
REQ-014 The block SHALL have port misalign_o, output, 1 bit: one-cycle pulse on a rejected misaligned target.

Function
REQ-015 pc SHALL be driven only from a register; it SHALL have no combinational path from any input.
REQ-016 The FSM SHALL have three states: S_RESET (ce=0), S_RUN, S_HOLD (redirect_pending_o=1).
REQ-017 S_RESET SHALL go to S_RUN on the first cycle with rst=1, setting ce=1 and keeping pc=RESET_VECTOR.
REQ-018 Per-cycle priority SHALL be: reset > flush > branch_flag_i > held redirect > sequential advance.
REQ-019 flush=1 SHALL set pc<=new_pc, clear any held redirect and go to S_RUN, regardless of stall and pc_read_ready.
REQ-020 A branch with pc_read_ready=1 and stall=0 SHALL set pc<=target next cycle and leave the state as S_RUN.
REQ-021 A branch with pc_read_ready=0 or stall=1 SHALL capture the target into the hold register, leave pc unchanged and enter S_HOLD.
REQ-022 A new branch arriving in S_HOLD SHALL overwrite the held target (latest wins).
REQ-023 In S_HOLD, pc_read_ready=1 with stall=0 SHALL set pc<=held target, clear the hold and go to S_RUN.
REQ-024 In S_RUN with no redirect, pc_read_ready=1 and stall=0, the block SHALL set pc <= (pc & ~(STEP-1)) + STEP, modulo 2^ADDR_W (wraps to 0).
REQ-025 With stall=1 or pc_read_ready=0 and no redirect or flush, pc SHALL hold its value.
REQ-026 With ALIGN_CHECK=1, a branch target with target[1:0]!=0 SHALL be dropped: no pc change, no capture, misalign_o=1 for exactly one cycle.
REQ-027 With ALIGN_CHECK=0, targets and new_pc SHALL use bits [1:0] forced to 0.
REQ-028 new_pc SHALL never raise misalign_o.

Reset
REQ-029 While rst=0 at a rising clk edge: pc<=RESET_VECTOR, ce<=0, redirect_pending_o<=0, misalign_o<=0, hold register<=0, state<=S_RESET.
REQ-030 Reset asserted mid-operation, including during S_HOLD, SHALL discard the held redirect.

Structure
REQ-031 RstEnable (1'b0), ChipEnable/ChipDisable, the default reset vector, the instruction-size constant and the FSM state encodings SHALL live in the shared defines file.
REQ-032 The block SHALL be a single module with no sub-modules; the alignment/step logic SHALL stay inline.

Verification
REQ-033 Reset release: rst 0->1 -> ce=0 on the first cycle, then ce=1 with pc=BFC00000; with ready held high, pc=BFC00004 on the next cycle.
REQ-034 Held branch: target 80001000 with pc_read_ready=0 for 3 cycles -> pc unchanged and redirect_pending_o=1; on the ready cycle -> pc=80001000, pending=0.
REQ-035 Branch overwrite plus flush: targets 100 then 200 while held, then flush with new_pc=BFC00380 on the same cycle as ready -> pc=BFC00380 and pending cleared.
REQ-036 FETCH_WIDTH=4: branch to 00000104, then ready -> pc=00000110; pc=FFFFFFF0 plus ready -> pc=00000000.
REQ-037 Misalign: target 00000102 with ALIGN_CHECK=1 -> misalign_o=1 for one cycle, pc and state unchanged; with ALIGN_CHECK=0 -> pc=00000100.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch PC generator:
// reset/enable levels, vectors and FSM encodings.
package pc_gen_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC00000;
  localparam int          INST_BYTES       = 4;

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_RUN   = 2'b01,
    S_HOLD  = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, branch
// redirects held until fetch accepts, flush override.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR =
    ADDR_W'(DEF_RESET_VECTOR),
  parameter int              FETCH_WIDTH  = 1,
  parameter int              ALIGN_CHECK  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              pc_read_ready,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redirect_pending_o,
  output logic              misalign_o
);

  localparam int STEP = INST_BYTES * FETCH_WIDTH;
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] MASK = ~(STEP_V - 1'b1);

  pc_state_e         state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [ADDR_W-1:0] hold_q, hold_n;
  logic              ce_q, ce_n;
  logic              mis_q, mis_n;

  logic              go;
  logic              tgt_bad;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] npc;

  assign go = pc_read_ready & ~stall;

  assign tgt_bad = (ALIGN_CHECK != 0) &&
                   (branch_target_address_i[1:0] != 2'b00);

  assign tgt = (ALIGN_CHECK != 0) ? branch_target_address_i :
               {branch_target_address_i[ADDR_W-1:2], 2'b00};

  assign npc = (ALIGN_CHECK != 0) ? new_pc :
               {new_pc[ADDR_W-1:2], 2'b00};

  // next-state and next-pc selection by redirect priority
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    hold_n  = hold_q;
    ce_n    = ce_q;
    mis_n   = 1'b0;
    unique case (state_q)
      S_RESET: begin
        state_n = S_RUN;
        ce_n    = ChipEnable;
      end
      S_RUN, S_HOLD: begin
        if (flush) begin
          pc_n    = npc;
          hold_n  = '0;
          state_n = S_RUN;
        end else if (branch_flag_i) begin
          if (tgt_bad) begin
            mis_n = 1'b1;
          end else if (go) begin
            pc_n    = tgt;
            hold_n  = '0;
            state_n = S_RUN;
          end else begin
            hold_n  = tgt;
            state_n = S_HOLD;
          end
        end else if (state_q == S_HOLD) begin
          if (go) begin
            pc_n    = hold_q;
            hold_n  = '0;
            state_n = S_RUN;
          end
        end else if (go) begin
          pc_n = (pc_q & MASK) + STEP_V;
        end
      end
      default: begin
        state_n = S_RESET;
        ce_n    = ChipDisable;
      end
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= S_RESET;
      pc_q    <= RESET_VECTOR;
      hold_q  <= '0;
      ce_q    <= ChipDisable;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      hold_q  <= hold_n;
      ce_q    <= ce_n;
      mis_q   <= mis_n;
    end
  end

  assign pc                 = pc_q;
  assign ce                 = ce_q;
  assign misalign_o         = mis_q;
  assign redirect_pending_o = (state_q == S_HOLD);

endmodule
